// File: rtl/predictor_multi_slot_if.sv
// Fetch request, registered prediction and resolution update signals of the
// multi-slot branch predictor.
interface predictor_multi_slot_if #(
  parameter int unsigned PC_W    = 32,
  parameter int unsigned FETCH_W = 2,
  parameter int unsigned GHR_W   = 8
);
  localparam int unsigned SLOT_W = (FETCH_W > 1) ? $clog2(FETCH_W) : 1;

  logic                   req_valid_i;
  logic [PC_W-1:0]        pc_i;
  logic                   if_allowin_i;

  logic                   ready_o;
  logic                   pred_valid_o;
  logic                   pred_taken_o;
  logic [SLOT_W-1:0]      pred_slot_o;
  logic [PC_W-1:0]        pred_target_o;
  logic [FETCH_W-1:0]     pred_hit_o;
  logic [2*FETCH_W-1:0]   pred_ctr_o;
  logic [GHR_W-1:0]       pred_ghr_o;

  logic                   upd_valid_i;
  logic [PC_W-1:0]        upd_pc_i;
  logic                   upd_taken_i;
  logic [PC_W-1:0]        upd_target_i;
  logic [GHR_W-1:0]       upd_ghr_i;
  logic                   upd_mispredict_i;

  modport slave (
    input  req_valid_i, pc_i, if_allowin_i,
    input  upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i, upd_ghr_i, upd_mispredict_i,
    output ready_o, pred_valid_o, pred_taken_o, pred_slot_o, pred_target_o,
    output pred_hit_o, pred_ctr_o, pred_ghr_o
  );

  modport master (
    output req_valid_i, pc_i, if_allowin_i,
    output upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i, upd_ghr_i, upd_mispredict_i,
    input  ready_o, pred_valid_o, pred_taken_o, pred_slot_o, pred_target_o,
    input  pred_hit_o, pred_ctr_o, pred_ghr_o
  );
endinterface

// File: rtl/predictor_multi_slot.sv
// Multi-slot branch predictor: gshare PHT, tagged direct-mapped BTB and a
// speculative GHR, with a registered one-cycle-latency prediction per fetch group.
module predictor_multi_slot #(
  parameter int unsigned PC_W      = 32,
  parameter int unsigned FETCH_W   = 2,
  parameter int unsigned PHT_IDX_W = 10,
  parameter int unsigned BTB_IDX_W = 6,
  parameter int unsigned TAG_W     = 8,
  parameter int unsigned GHR_W     = 8,
  parameter bit          GSHARE    = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  predictor_multi_slot_if.slave bus
);
  localparam int unsigned SLOT_W    = (FETCH_W > 1) ? $clog2(FETCH_W) : 1;
  localparam int unsigned PHT_DEPTH = 1 << PHT_IDX_W;
  localparam int unsigned BTB_DEPTH = 1 << BTB_IDX_W;
  localparam int unsigned CNT_W     = (PHT_IDX_W > BTB_IDX_W) ? PHT_IDX_W : BTB_IDX_W;

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  state_e                  r_state, w_state_nxt;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_ready;
  logic [GHR_W-1:0]        r_ghr;

  logic [1:0]              r_pht       [PHT_DEPTH];
  logic                    r_btb_valid [BTB_DEPTH];
  logic [TAG_W-1:0]        r_btb_tag   [BTB_DEPTH];
  logic [PC_W-1:0]         r_btb_tgt   [BTB_DEPTH];

  logic                    r_pred_valid, r_pred_taken;
  logic [SLOT_W-1:0]       r_pred_slot;
  logic [PC_W-1:0]         r_pred_target;
  logic [FETCH_W-1:0]      r_pred_hit;
  logic [2*FETCH_W-1:0]    r_pred_ctr;
  logic [GHR_W-1:0]        r_pred_ghr;

  logic [FETCH_W-1:0][PC_W-1:0] w_addr;
  logic [FETCH_W-1:0]      w_hit, w_taken;
  logic [2*FETCH_W-1:0]    w_ctr;
  logic [SLOT_W-1:0]       w_slot_sel;
  logic [PC_W-1:0]         w_tgt_sel;
  logic [PHT_IDX_W-1:0]    w_ghr_ext, w_upd_ghr_ext, w_upd_pht_idx;
  logic [BTB_IDX_W-1:0]    w_upd_btb_idx;
  logic [TAG_W-1:0]        w_upd_tag;
  logic [1:0]              w_upd_ctr_old, w_upd_ctr;
  logic                    w_upd_en, w_load, w_load_req;
  logic                    w_pht_sweep_en, w_btb_sweep_en;
  logic                    w_unused;

  // Sweep from INIT to RUN once the counter has visited every table entry
  always_comb begin
    w_state_nxt = r_state;
    if (r_state == ST_INIT && (&r_cnt)) w_state_nxt = ST_RUN;
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_state <= ST_INIT;
      r_cnt   <= '0;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ready <= (w_state_nxt == ST_RUN);
      if (r_state == ST_INIT) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign w_pht_sweep_en = ((r_cnt >> PHT_IDX_W) == '0);
  assign w_btb_sweep_en = ((r_cnt >> BTB_IDX_W) == '0);
  assign w_ghr_ext      = GSHARE ? PHT_IDX_W'(r_ghr) : '0;
  assign w_upd_ghr_ext  = GSHARE ? PHT_IDX_W'(bus.upd_ghr_i) : '0;

  assign w_upd_en       = (r_state == ST_RUN) && bus.upd_valid_i;
  assign w_upd_pht_idx  = bus.upd_pc_i[PHT_IDX_W+1:2] ^ w_upd_ghr_ext;
  assign w_upd_btb_idx  = bus.upd_pc_i[BTB_IDX_W+1:2];
  assign w_upd_tag      = bus.upd_pc_i[BTB_IDX_W+TAG_W+1:BTB_IDX_W+2];
  assign w_upd_ctr_old  = r_pht[w_upd_pht_idx];

  always_comb begin
    w_upd_ctr = w_upd_ctr_old;
    if (bus.upd_taken_i) begin
      if (w_upd_ctr_old != 2'b11) w_upd_ctr = w_upd_ctr_old + 2'd1;
    end else begin
      if (w_upd_ctr_old != 2'b00) w_upd_ctr = w_upd_ctr_old - 2'd1;
    end
  end

  // Tables: sweep writes in INIT, resolution writes in RUN
  always_ff @(posedge clk) begin
    if (!rst_n && r_state == ST_INIT) begin
      if (w_pht_sweep_en) r_pht[r_cnt[PHT_IDX_W-1:0]] <= 2'b01;
      if (w_btb_sweep_en) r_btb_valid[r_cnt[BTB_IDX_W-1:0]] <= 1'b0;
    end else if (!rst_n && w_upd_en) begin
      r_pht[w_upd_pht_idx] <= w_upd_ctr;
      if (bus.upd_taken_i) begin
        r_btb_valid[w_upd_btb_idx] <= 1'b1;
        r_btb_tag[w_upd_btb_idx]   <= w_upd_tag;
        r_btb_tgt[w_upd_btb_idx]   <= bus.upd_target_i;
      end
    end
  end

  always_comb begin
    for (int k = 0; k < FETCH_W; k++) w_addr[k] = bus.pc_i + PC_W'(4 * k);
  end

  // Per-slot lookup; walking slots high to low leaves the lowest taken slot selected
  always_comb begin
    w_hit      = '0;
    w_taken    = '0;
    w_ctr      = '0;
    w_slot_sel = '0;
    w_tgt_sel  = '0;
    for (int k = FETCH_W - 1; k >= 0; k--) begin
      w_ctr[2*k +: 2] = r_pht[w_addr[k][PHT_IDX_W+1:2] ^ w_ghr_ext];
      w_hit[k]   = r_btb_valid[w_addr[k][BTB_IDX_W+1:2]] &&
                   (r_btb_tag[w_addr[k][BTB_IDX_W+1:2]] ==
                    w_addr[k][BTB_IDX_W+TAG_W+1:BTB_IDX_W+2]);
      w_taken[k] = w_hit[k] & w_ctr[2*k+1];
      if (w_taken[k]) begin
        w_slot_sel = SLOT_W'(k);
        w_tgt_sel  = r_btb_tgt[w_addr[k][BTB_IDX_W+1:2]];
      end
    end
  end

  assign w_load     = bus.if_allowin_i;
  assign w_load_req = w_load && bus.req_valid_i && r_ready;

  // A mispredict restore overrides any speculative shift in the same cycle
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_ghr <= '0;
    end else if (w_upd_en && bus.upd_mispredict_i) begin
      r_ghr <= {bus.upd_ghr_i[GHR_W-2:0], bus.upd_taken_i};
    end else if (w_load_req) begin
      if (|w_taken)    r_ghr <= {r_ghr[GHR_W-2:0], 1'b1};
      else if (|w_hit) r_ghr <= {r_ghr[GHR_W-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_pred_valid  <= 1'b0;
      r_pred_taken  <= 1'b0;
      r_pred_slot   <= '0;
      r_pred_target <= '0;
      r_pred_hit    <= '0;
      r_pred_ctr    <= '0;
      r_pred_ghr    <= '0;
    end else if (w_load) begin
      r_pred_valid  <= bus.req_valid_i && r_ready;
      r_pred_taken  <= |w_taken;
      r_pred_slot   <= w_slot_sel;
      r_pred_target <= w_tgt_sel;
      r_pred_hit    <= w_hit;
      r_pred_ctr    <= w_ctr;
      r_pred_ghr    <= r_ghr;
    end
  end

  assign bus.ready_o       = r_ready;
  assign bus.pred_valid_o  = r_pred_valid;
  assign bus.pred_taken_o  = r_pred_taken;
  assign bus.pred_slot_o   = r_pred_slot;
  assign bus.pred_target_o = r_pred_target;
  assign bus.pred_hit_o    = r_pred_hit;
  assign bus.pred_ctr_o    = r_pred_ctr;
  assign bus.pred_ghr_o    = r_pred_ghr;

  // Address bits outside the index/tag fields are intentionally ignored
  assign w_unused = ^{w_addr, bus.upd_pc_i};

endmodule

// File: tb/tb_predictor_multi_slot.sv
// Self-checking bench for predictor_multi_slot: init sweep, table-driven
// prediction/update vectors through a scoreboard queue, and mid-run reset.
module tb_predictor_multi_slot;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  predictor_multi_slot_if intf ();
  predictor_multi_slot dut (.clk(clk), .rst_n(rst), .bus(intf));

  typedef struct {
    logic al, rq; logic [31:0] pc;
    logic uv, ut, um; logic [31:0] upc, utg; logic [7:0] ug;
    logic ev, et, es; logic [31:0] etg; logic [1:0] eh; logic [3:0] ec; logic [7:0] eg;
  } vec_t;

  typedef struct {
    logic ev, et, es; logic [31:0] etg; logic [1:0] eh; logic [3:0] ec; logic [7:0] eg;
  } exp_t;

  localparam logic [31:0] PA = 32'h1C00_0000;
  localparam logic [31:0] PB = 32'h1C00_0004;
  localparam logic [31:0] PS = 32'h1C00_0010;
  localparam logic [31:0] TA = 32'h1C00_0100;
  localparam logic [31:0] TS = 32'h1C00_0300;

  int   checks = 0;
  int   errors = 0;
  vec_t tv[$];
  exp_t sbq[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  function automatic vec_t mk(input logic al, rq, input logic [31:0] pc,
                              input logic uv, input logic [31:0] upc, input logic ut,
                              input logic [31:0] utg, input logic [7:0] ug, input logic um,
                              input logic ev, et, es, input logic [31:0] etg,
                              input logic [1:0] eh, input logic [3:0] ec, input logic [7:0] eg);
    vec_t v;
    v.al = al; v.rq = rq; v.pc = pc; v.uv = uv; v.upc = upc; v.ut = ut;
    v.utg = utg; v.ug = ug; v.um = um; v.ev = ev; v.et = et; v.es = es;
    v.etg = etg; v.eh = eh; v.ec = ec; v.eg = eg;
    return v;
  endfunction

  task automatic apply(input vec_t v, input string nm);
    exp_t e;
    @(negedge clk);
    intf.if_allowin_i = v.al; intf.req_valid_i = v.rq; intf.pc_i = v.pc;
    intf.upd_valid_i = v.uv; intf.upd_pc_i = v.upc; intf.upd_taken_i = v.ut;
    intf.upd_target_i = v.utg; intf.upd_ghr_i = v.ug; intf.upd_mispredict_i = v.um;
    e.ev = v.ev; e.et = v.et; e.es = v.es; e.etg = v.etg; e.eh = v.eh; e.ec = v.ec; e.eg = v.eg;
    sbq.push_back(e);
    @(posedge clk); #1;
    if (sbq.size() == 0) begin
      chk({nm, "_sb_empty"}, 64'd1, 64'd0);
    end else begin
      e = sbq.pop_front();
      chk({nm, "_valid"},  64'(intf.pred_valid_o),  64'(e.ev));
      chk({nm, "_taken"},  64'(intf.pred_taken_o),  64'(e.et));
      chk({nm, "_slot"},   64'(intf.pred_slot_o),   64'(e.es));
      chk({nm, "_target"}, 64'(intf.pred_target_o), 64'(e.etg));
      chk({nm, "_hit"},    64'(intf.pred_hit_o),    64'(e.eh));
      chk({nm, "_ctr"},    64'(intf.pred_ctr_o),    64'(e.ec));
      chk({nm, "_ghr"},    64'(intf.pred_ghr_o),    64'(e.eg));
    end
  endtask

  // Counts cycles from reset release until ready_o; pred_valid_o must stay low
  task automatic wait_init(input string nm);
    int n = 0;
    logic bad = 1'b0;
    while (n < 2000) begin
      @(posedge clk); #1;
      n++;
      if (intf.pred_valid_o) bad = 1'b1;
      if (intf.ready_o) break;
    end
    chk({nm, "_len"}, 64'(n), 64'd1024);
    chk({nm, "_valid_low"}, 64'(bad), 64'd0);
  endtask

  initial begin
    intf.if_allowin_i = 1'b0; intf.req_valid_i = 1'b0; intf.pc_i = '0;
    intf.upd_valid_i = 1'b0; intf.upd_pc_i = '0; intf.upd_taken_i = 1'b0;
    intf.upd_target_i = '0; intf.upd_ghr_i = '0; intf.upd_mispredict_i = 1'b0;

    //      al rq pc         uv upc          ut utg  ug     um  ev et es etg  eh     ec       eg
    tv.push_back(mk(1, 1, PA, 0, 0, 0, 0, 8'h00, 0,             1, 0, 0, 0,  2'b00, 4'b0101, 8'h00));
    tv.push_back(mk(1, 0, PA, 1, PB, 1, TA, 8'h00, 0,           0, 0, 0, 0,  2'b00, 4'b0101, 8'h00));
    tv.push_back(mk(1, 0, PA, 1, PB, 1, TA, 8'h00, 0,           0, 1, 1, TA, 2'b10, 4'b1001, 8'h00));
    tv.push_back(mk(1, 1, PA, 0, 0, 0, 0, 8'h00, 0,             1, 1, 1, TA, 2'b10, 4'b1101, 8'h00));
    tv.push_back(mk(0, 1, 32'h2000_0000, 0, 0, 0, 0, 8'h00, 0,  1, 1, 1, TA, 2'b10, 4'b1101, 8'h00));
    tv.push_back(mk(1, 1, PB, 0, 0, 0, 0, 8'h00, 0,             1, 0, 0, 0,  2'b01, 4'b0101, 8'h01));
    tv.push_back(mk(0, 0, PA, 1, PB, 1, TA, 8'h03, 1,           1, 0, 0, 0,  2'b01, 4'b0101, 8'h01));
    tv.push_back(mk(0, 0, PA, 1, PB, 1, TA, 8'h07, 0,           1, 0, 0, 0,  2'b01, 4'b0101, 8'h01));
    tv.push_back(mk(0, 0, PA, 1, PB, 1, TA, 8'h0F, 0,           1, 0, 0, 0,  2'b01, 4'b0101, 8'h01));
    tv.push_back(mk(1, 1, PA, 0, 0, 0, 0, 8'h00, 0,             1, 1, 1, TA, 2'b10, 4'b1001, 8'h07));
    tv.push_back(mk(1, 1, PA, 1, 32'h1C00_0400, 0, 0, 8'h35, 1, 1, 1, 1, TA, 2'b10, 4'b1001, 8'h0F));
    tv.push_back(mk(1, 1, PA, 0, 0, 0, 0, 8'h00, 0,             1, 0, 0, 0,  2'b10, 4'b0101, 8'h6A));
    for (int i = 0; i < 5; i++)
      tv.push_back(mk(0, 0, PA, 1, PS, 0, 0, 8'h00, (i == 4) ? 1'b1 : 1'b0,
                      1, 0, 0, 0, 2'b10, 4'b0101, 8'h6A));
    tv.push_back(mk(1, 1, PS, 0, 0, 0, 0, 8'h00, 0,             1, 0, 0, 0,  2'b00, 4'b0100, 8'h00));
    for (int i = 0; i < 4; i++)
      tv.push_back(mk(0, 0, PS, 1, PS, 1, TS, 8'h00, 0,         1, 0, 0, 0,  2'b00, 4'b0100, 8'h00));
    tv.push_back(mk(1, 1, PS, 0, 0, 0, 0, 8'h00, 0,             1, 1, 0, TS, 2'b01, 4'b0111, 8'h00));
    tv.push_back(mk(0, 0, PS, 1, PS, 1, TS, 8'h00, 0,           1, 1, 0, TS, 2'b01, 4'b0111, 8'h00));
    tv.push_back(mk(1, 1, 32'h1C00_0014, 0, 0, 0, 0, 8'h00, 0,  1, 0, 0, 0,  2'b00, 4'b0111, 8'h01));

    // Reset state
    @(posedge clk); #1;
    chk("rst_ready", 64'(intf.ready_o), 64'd0);
    chk("rst_valid", 64'(intf.pred_valid_o), 64'd0);
    chk("rst_taken", 64'(intf.pred_taken_o), 64'd0);
    chk("rst_slot",  64'(intf.pred_slot_o), 64'd0);
    chk("rst_target", 64'(intf.pred_target_o), 64'd0);
    chk("rst_hit", 64'(intf.pred_hit_o), 64'd0);
    chk("rst_ctr", 64'(intf.pred_ctr_o), 64'd0);
    chk("rst_ghr", 64'(intf.pred_ghr_o), 64'd0);

    // Requests and a mispredicting taken update held through INIT must be ignored
    @(negedge clk);
    rst = 1'b0;
    intf.if_allowin_i = 1'b1; intf.req_valid_i = 1'b1; intf.pc_i = PB;
    intf.upd_valid_i = 1'b1; intf.upd_pc_i = PB; intf.upd_taken_i = 1'b1;
    intf.upd_target_i = TA; intf.upd_ghr_i = 8'h35; intf.upd_mispredict_i = 1'b1;
    wait_init("init");

    foreach (tv[i]) apply(tv[i], $sformatf("v%0d", i));

    // Reset in RUN: ready drops, the sweep restarts and clears trained entries
    @(negedge clk);
    rst = 1'b1;
    intf.req_valid_i = 1'b0; intf.upd_valid_i = 1'b0;
    @(posedge clk); #1;
    chk("rerst_ready", 64'(intf.ready_o), 64'd0);
    chk("rerst_valid", 64'(intf.pred_valid_o), 64'd0);
    chk("rerst_ghr", 64'(intf.pred_ghr_o), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    wait_init("reinit");
    apply(mk(1, 1, PS, 0, 0, 0, 0, 8'h00, 0, 1, 0, 0, 0, 2'b00, 4'b0101, 8'h00), "post");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
